seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
Parametrised successor to the fixed six-digit seven-segment driver. It converts a binary value to BCD with a sequential shift-add-3 engine (no combinational dividers) and holds the result in a display register. It time-multiplexes NUM_DIGITS digits from a single-clock enable tick, with no derived clocks. It adds per-digit decimal points, global blanking, overflow indication and a load/busy handshake; it sits between the CPU debug data bus and the board LED pins.

Parameters:
NUM_DIGITS, 6, number of digits driven (1..8)
DATA_W, 20, width of binary input
SCAN_DIV, 50000, clk cycles per digit slot (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
data  in  DATA_W  unsigned binary value to display
data_valid  in  1  load strobe; sampled only when busy=0
busy  out  1  conversion in progress
dp  in  NUM_DIGITS  decimal point per digit, 1=lit, sampled live at each tick
blank  in  1  1 = all digits off
seg_sel  out  NUM_DIGITS  one-hot active-low digit select, bit0 = least-significant digit
seg_control  out  8  active-low segments, bit7=dp, bits6:0 = g..a

Behaviour:
- Reset (clk edge with reset=1): busy=0, state IDLE, seg_sel all ones, seg_control=8'hFF, scan counter=0, digit index=0, display register = all zeros, ovf flag=0.
- Converter FSM, states IDLE -> CONV -> DONE -> IDLE.
- IDLE: on data_valid=1, capture data into shift reg, clear BCD reg (4*NUM_DIGITS bits), set bit counter = DATA_W, set ovf = (data >= 10^NUM_DIGITS, elaboration-time constant; never true if 2^DATA_W <= 10^NUM_DIGITS), go CONV, busy=1 from next cycle.
- CONV: each cycle, add 3 to every BCD nibble >=5, then shift {BCD,shift} left by one, decrement counter; after DATA_W shifts go DONE.
- DONE (1 cycle): copy BCD to display register and ovf to the display ovf flag; go IDLE; busy=0 from next cycle.
- Latency: data_valid at cycle 0 -> busy high cycles 1..DATA_W+1 -> display register updated at edge ending cycle DATA_W+1 -> shown from next scan tick.
- data_valid while busy=1 is ignored (no queueing). Reset mid-conversion aborts the conversion; display returns to zeros.
- Scan: counter counts 0..SCAN_DIV-1 and wraps; tick=1 when counter=SCAN_DIV-1. On tick, index advances (wraps NUM_DIGITS-1 -> 0); seg_sel and seg_control are registered in the same edge from the new index.
- Segment codes: 0..9 = C0,F9,A4,B0,99,92,82,F8,80,90 (hex, dp bit set); dp[idx]=1 clears bit7. Display ovf=1 -> every digit shows dash 8'hBF (dp still applies).
- blank=1: seg_sel forced all ones at the next clk edge, independent of tick; scanning and conversion continue. blank=0 restores normal output at the next tick.
- Display register changes apply only from the next tick (no mid-slot glitch).

Optional Feature:
SEG_LZB_EN: leading-zero blanking. Defined: digits above the most significant nonzero digit output 8'hFF, with bit7 still controlled by dp; digit 0 is always shown; this does not apply when ovf=1. Undefined: all digits show their value, including leading zeros.

Test Plan:
- Reset with SCAN_DIV=4: seg_sel=6'b111111, seg_control=8'hFF, busy=0; after first tick seg_sel=6'b111110, seg_control=8'hC0.
- data=123456, data_valid 1 cycle: busy high exactly 21 cycles; the following scan cycle shows 6,5,4,3,2,1 on sel bits 0..5 with codes 82,92,99,B0,A4,F9.
- data=20'd1000000: every digit 8'hBF; dp=6'b000100 -> digit 2 shows 8'h3F.
- Second data_valid (data=7) 5 cycles into a conversion of 999999: ignored; display shows 999999.
- reset asserted in cycle 10 of a conversion: busy=0 next cycle, display zeros; blank=1 -> seg_sel all ones within 1 cycle.
- SEG_LZB_EN defined, data=42: digits 2..5 show FF, digit1=99, digit0=A4; data=0 -> digit0=C0, others FF.

Source files
------------

// File: rtl/seg_scan_if.sv
// Bus between the CPU debug side and the seven-segment scan driver:
// load/busy handshake, display modifiers and the LED pin outputs.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_W     = 20
);
  logic [DATA_W-1:0]     data;
  logic                  data_valid;
  logic                  busy;
  logic [NUM_DIGITS-1:0] dp;
  logic                  blank;
  logic [NUM_DIGITS-1:0] seg_sel;
  logic [7:0]            seg_control;

  modport master (
    output data, data_valid, dp, blank,
    input  busy, seg_sel, seg_control
  );

  modport slave (
    input  data, data_valid, dp, blank,
    output busy, seg_sel, seg_control
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment driver with sequential shift-add-3 BCD conversion.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_driver #(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_W     = 20,
  parameter int SCAN_DIV   = 50000
) (
  input logic       clk,
  input logic       reset,
  seg_scan_if.slave bus
);
  localparam int BCD_W  = 4 * NUM_DIGITS;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] OVF_LIMIT = pow10(NUM_DIGITS);

  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] c;
    case (nib)
      4'd0:    c = 8'hC0;
      4'd1:    c = 8'hF9;
      4'd2:    c = 8'hA4;
      4'd3:    c = 8'hB0;
      4'd4:    c = 8'h99;
      4'd5:    c = 8'h92;
      4'd6:    c = 8'h82;
      4'd7:    c = 8'hF8;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h90;
      default: c = 8'hFF;
    endcase
    return c;
  endfunction

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [DATA_W-1:0]  shift_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic [BCD_W-1:0]   disp_reg;
  logic [CNT_W-1:0]   bit_cnt;
  logic               ovf_reg;
  logic               disp_ovf;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [IDX_W-1:0]   idx;
  logic               tick;
  logic [3:0]         nib;
  logic               lead_zero;
  logic [7:0]         code;

  // Converter FSM
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.data_valid) state_next = CONV;
      CONV:    if (bit_cnt == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
  end

  // Conversion datapath and display register
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_reg <= '0;
      disp_ovf <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.data_valid) begin
          shift_reg <= bus.data;
          bcd_reg   <= '0;
          bit_cnt   <= CNT_W'(DATA_W);
          ovf_reg   <= (64'(bus.data) >= OVF_LIMIT);
        end
        CONV: begin
          {bcd_reg, shift_reg} <= {bcd_adjust(bcd_reg), shift_reg} << 1;
          bit_cnt              <= bit_cnt - CNT_W'(1);
        end
        DONE: begin
          disp_reg <= bcd_reg;
          disp_ovf <= ovf_reg;
        end
        default: ;
      endcase
    end
  end

  // Segment pattern for the digit that the coming tick will select
  always_comb begin
    tick      = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    nib       = disp_reg[4*int'(idx) +: 4];
    lead_zero = 1'b0;
`ifdef SEG_LZB_EN
    lead_zero = (idx != '0) && ((disp_reg >> (4*int'(idx))) == '0);
`endif
    if (disp_ovf)       code = 8'hBF;
    else if (lead_zero) code = 8'hFF;
    else                code = seg_decode(nib);
    if (bus.dp[idx]) code[7] = 1'b0;
  end

  // Scan timing and registered pin outputs; blank overrides selects every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt        <= '0;
      idx             <= '0;
      bus.seg_sel     <= '1;
      bus.seg_control <= 8'hFF;
    end else begin
      scan_cnt <= tick ? '0 : scan_cnt + SCAN_W'(1);
      if (tick) begin
        idx             <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        bus.seg_control <= code;
      end
      if (bus.blank)  bus.seg_sel <= '1;
      else if (tick)  bus.seg_sel <= ~(NUM_DIGITS'(1) << idx);
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomised bench for seg_scan_driver with a decimal-arithmetic reference model
// and literal frame checks for the documented display cases.
module tb_seg_scan_driver;
  localparam int     ND    = 6;
  localparam int     DW    = 20;
  localparam int     SD    = 4;
  localparam longint LIMIT = 1000000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg_scan_if #(.NUM_DIGITS(ND), .DATA_W(DW)) bus ();

  seg_scan_driver #(.NUM_DIGITS(ND), .DATA_W(DW), .SCAN_DIV(SD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Reference model: displayed value as an integer, conversion as a countdown
  longint          m_val, m_pend;
  bit              m_ovf, tk;
  int              m_left, m_scan, m_idx;
  logic [ND-1:0]   m_sel;
  logic [7:0]      m_ctrl;
  logic [7:0]      frame [ND];

  function automatic logic [7:0] exp_code(longint v, bit ovf, int d, bit dpb);
    logic [7:0] c;
    longint p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    if (ovf) c = 8'hBF;
`ifdef SEG_LZB_EN
    else if (d > 0 && v < p) c = 8'hFF;
`endif
    else c = seg_tab[int'((v / p) % 10)];
    if (dpb) c[7] = 1'b0;
    return c;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0; m_val = 0; m_ovf = 0; m_scan = 0; m_idx = 0;
      m_sel = '1; m_ctrl = 8'hFF;
    end else begin
      tk = (m_scan == SD - 1);
      if (tk) m_ctrl = exp_code(m_val, m_ovf, m_idx, bus.dp[m_idx]);
      if (bus.blank) m_sel = '1;
      else if (tk) begin m_sel = '1; m_sel[m_idx] = 1'b0; end
      if (tk) m_idx = (m_idx + 1) % ND;
      m_scan = tk ? 0 : m_scan + 1;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin m_val = m_pend; m_ovf = (m_pend >= LIMIT); end
      end else if (bus.data_valid) begin
        m_pend = longint'(bus.data);
        m_left = DW + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      vectors++;
      if (bus.busy !== (m_left > 0) || bus.seg_sel !== m_sel || bus.seg_control !== m_ctrl) begin
        miscompares++;
        $display("FAIL cycle t=%0t busy=%b req %b sel=%b req %b ctrl=%h req %h",
                 $time, bus.busy, (m_left > 0), bus.seg_sel, m_sel, bus.seg_control, m_ctrl);
      end
    end
  end

  task automatic check(string name, int act, int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic load(logic [DW-1:0] v);
    bus.data = v;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("busy_timeout", 1, 0);
  endtask

  task automatic grab_frame();
    for (int d = 0; d < ND; d++) frame[d] = 'x;
    repeat ((ND + 1) * SD) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++)
        if (bus.seg_sel == ~(ND'(1) << d)) frame[d] = bus.seg_control;
    end
  endtask

  task automatic check_frame(string name, logic [8*ND-1:0] req);
    grab_frame();
    for (int d = 0; d < ND; d++) begin
      vectors++;
      if (frame[d] !== req[8*d +: 8]) begin
        miscompares++;
        $display("FAIL %s digit%0d actual=%h required=%h", name, d, frame[d], req[8*d +: 8]);
      end
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; bus.data = '0; bus.data_valid = 1'b0; bus.dp = '0; bus.blank = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_en = 1'b1;
    check("reset_sel", int'(bus.seg_sel), 'h3F);
    check("reset_ctrl", int'(bus.seg_control), 'hFF);
    check("reset_busy", int'(bus.busy), 0);
    repeat (SD) @(negedge clk);
    check("tick1_sel", int'(bus.seg_sel), 'h3E);
    check("tick1_ctrl", int'(bus.seg_control), 'hC0);

    load(20'd123456);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    check("busy_len", n, DW + 1);
    check_frame("f123456", {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82});

    load(20'd1000000);
    wait_idle();
    check_frame("fovf", {6{8'hBF}});
    bus.dp = 6'b000100;
    check_frame("fovf_dp", {8'hBF, 8'hBF, 8'hBF, 8'h3F, 8'hBF, 8'hBF});
    bus.dp = '0;

    load(20'd999999);
    repeat (4) @(negedge clk);
    load(20'd7);
    wait_idle();
    check_frame("f999999", {6{8'h90}});

    load(20'd123456);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
`ifdef SEG_LZB_EN
    check_frame("fabort", {{5{8'hFF}}, 8'hC0});
`else
    check_frame("fabort", {6{8'hC0}});
`endif
    bus.blank = 1'b1;
    @(negedge clk);
    check("blank_sel", int'(bus.seg_sel), 'h3F);
    repeat (2 * SD) @(negedge clk);
    bus.blank = 1'b0;

    load(20'd42);
    wait_idle();
`ifdef SEG_LZB_EN
    check_frame("f42", {{4{8'hFF}}, 8'h99, 8'hA4});
`else
    check_frame("f42", {{4{8'hC0}}, 8'h99, 8'hA4});
`endif
    load(20'd0);
    wait_idle();
`ifdef SEG_LZB_EN
    check_frame("f0", {{5{8'hFF}}, 8'hC0});
`else
    check_frame("f0", {6{8'hC0}});
`endif

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      case ($urandom_range(0, 3))
        0:       bus.data = DW'($urandom);
        1:       bus.data = DW'($urandom_range(0, 99));
        default: bus.data = DW'($urandom_range(0, 999999));
      endcase
      bus.data_valid = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) bus.dp = ND'($urandom);
      if ($urandom_range(0, 30) == 0) bus.blank = ~bus.blank;
      reset = ($urandom_range(0, 400) == 0);
    end
    @(negedge clk);
    reset = 1'b0; bus.data_valid = 1'b0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
